// File: rtl/rv32i_types.sv
// ============================================================================
// rv32i_types : shared queue-entry type and issue-queue sizing constants
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rv32i_types;

   localparam int IQ_DEPTH_ALU   = 8;
   localparam int IQ_DEPTH_MEM   = 8;
   // Entries kept free so dispatch can stall before the queue actually fills.
   localparam int IQ_AFULL_SLACK = 2;

   typedef struct packed {
      logic [6:0] opcode;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [9:0] rob_tag;
   } queue_item_t;

endpackage

`default_nettype wire

// File: rtl/iq_ptr.sv
// ============================================================================
// iq_ptr   : wrapping queue pointer with increment and synchronous clear
// Revision : 1.0
// ============================================================================
`default_nettype none

module iq_ptr #(
   parameter int PTR_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   // Power-of-two depth lets the pointer wrap by plain overflow.
   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = '0;
      end else if (inc) begin
         ptr_d = ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

`default_nettype wire

// File: rtl/issue_queue.sv
// ============================================================================
// issue_queue : circular FIFO between dispatch and register-read, with flush,
//               occupancy status and sticky error flags.
//               Optional macro ISSUEQ_BYPASS_EN: empty-queue push-through.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module issue_queue
   import rv32i_types::*;
#(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = IQ_DEPTH_ALU,
   parameter int AFULL_THRESH = DEPTH - IQ_AFULL_SLACK
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   input  logic                       flush,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       clr_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             overflow_q;
   logic             overflow_d;
   logic             underflow_q;
   logic             underflow_d;
   logic             is_empty;
   logic             is_full;
   logic             bypass;
   logic             pop_ok;
   logic             push_ok;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_W'(DEPTH));

`ifdef ISSUEQ_BYPASS_EN
   assign bypass = is_empty & push & pop;
`else
   assign bypass = 1'b0;
`endif

   // A pop frees the slot, so a push into a full queue still lands.
   assign pop_ok  = pop & ~is_empty;
   assign push_ok = push & (~is_full | pop_ok) & ~bypass;

   always_comb begin
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (clr_err) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (flush) begin
         count_d = '0;
      end else begin
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
         if (push & is_full & ~pop_ok) begin
            overflow_d = 1'b1;
         end
         if (pop & is_empty & ~bypass) begin
            underflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok & ~flush) begin
         mem_q[wr_ptr] <= din;
      end
   end

   iq_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (push_ok),
      .ptr (wr_ptr)
   );

   iq_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (pop_ok),
      .ptr (rd_ptr)
   );

   always_comb begin
      dout = '0;
      if (!is_empty) begin
         dout = mem_q[rd_ptr];
      end
`ifdef ISSUEQ_BYPASS_EN
      else if (push) begin
         dout = din;
      end
`endif
   end

   assign empty       = is_empty;
   assign full        = is_full;
   assign almost_full = (count_q >= CNT_W'(AFULL_THRESH));
   assign count       = count_q;
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_issue_queue.sv
// ============================================================================
// tb_issue_queue : scoreboard bench for issue_queue against a queue-based model
// Revision       : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_issue_queue;

   localparam int DEPTH = 8;
   localparam int AF    = 6;
`ifdef ISSUEQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk     = 1'b0;
   logic        rst     = 1'b0;
   logic        push    = 1'b0;
   logic        pop     = 1'b0;
   logic        flush   = 1'b0;
   logic        clr_err = 1'b0;
   logic [31:0] din     = '0;
   logic [31:0] dout;
   logic        empty;
   logic        full;
   logic        almost_full;
   logic        overflow;
   logic        underflow;
   logic [3:0]  count;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] mq[$];
   logic [31:0] sb[$];
   bit          m_ovf = 1'b0;
   bit          m_und = 1'b0;

   always #5 clk = ~clk;

   issue_queue #(.WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .din         (din),
      .pop         (pop),
      .dout        (dout),
      .flush       (flush),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow),
      .clr_err     (clr_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_status();
      chk("count", 32'(count), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_und));
      if (mq.size() != 0) chk("head", dout, mq[0]);
      else if (!(BYP && push)) chk("dout_empty", dout, 32'h0);
   endtask

   // Reference: FIFO as a queue; next state from the current inputs.
   task automatic model_cycle();
      bit e, f, popped, so, su;
      e = (mq.size() == 0);
      f = (mq.size() == DEPTH);
      popped = 1'b0; so = 1'b0; su = 1'b0;
      if (flush) begin
         mq.delete();
      end else if (BYP && e && push && pop) begin
         sb.push_back(din);
      end else begin
         if (pop) begin
            if (!e) begin
               sb.push_back(mq.pop_front());
               popped = 1'b1;
            end else begin
               su = 1'b1;
            end
         end
         if (push) begin
            if (!f || popped) mq.push_back(din);
            else so = 1'b1;
         end
      end
      m_ovf = so | (m_ovf & !clr_err);
      m_und = su | (m_und & !clr_err);
   endtask

   task automatic step(input bit p, input logic [31:0] d, input bit po, input bit fl, input bit ce);
      @(posedge clk);
      #1;
      check_status();
      push = p; din = d; pop = po; flush = fl; clr_err = ce;
      model_cycle();
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic async_reset();
      @(posedge clk);
      #1;
      check_status();
      push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("async_empty", 32'(empty), 32'h1);
      chk("async_count", 32'(count), 32'h0);
      mq.delete();
      m_ovf = 1'b0;
      m_und = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
   endtask

   // Monitor: every accepted pop must match the oldest scoreboard entry.
   always @(negedge clk) begin
      if (rst && pop && !flush && (!empty || (BYP && push))) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_data: got %0h expected no accepted pop at %0t", dout, $time);
         end else begin
            chk("pop_data", dout, sb.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #12 rst = 1'b1;

      step(1, 32'hA1, 0, 0, 0);
      step(1, 32'hA2, 0, 0, 0);
      step(1, 32'hA3, 0, 0, 0);
      idle();
      repeat (3) step(0, 32'h0, 1, 0, 0);
      idle();

      for (int i = 0; i < 9; i++) step(1, $urandom, 0, 0, 0);
      idle();
      step(0, 32'h0, 0, 0, 1);
      idle();

      step(1, 32'h55, 1, 0, 0);
      repeat (8) step(0, 32'h0, 1, 0, 0);
      idle();

      step(1, 32'd100, 0, 0, 0);
      for (int i = 1; i <= 20; i++) step(1, 32'd100 + 32'(i), 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);
      idle();

      step(0, 32'h0, 1, 0, 0);
      idle();
      step(0, 32'h0, 0, 0, 1);
      step(1, 32'h77, 1, 0, 0);
      idle();
      step(0, 32'h0, 1, 0, 1);
      idle();

      for (int i = 0; i < 5; i++) step(1, 32'hC0 + 32'(i), 0, 0, 0);
      step(1, 32'hDEAD, 1, 1, 0);
      idle();
      step(1, 32'h33, 0, 0, 0);
      idle();
      step(0, 32'h0, 1, 0, 0);

      for (int i = 0; i < 4; i++) step(1, 32'hE0 + 32'(i), 0, 0, 0);
      async_reset();
      step(1, 32'h10, 0, 0, 0);
      idle();
      step(0, 32'h0, 1, 0, 0);
      idle();

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50,
              $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
      end
      idle();
      idle();
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
